// File: rtl/micro_sequencer.sv
// micro_sequencer
//   Moore control sequencer for the 16-opcode SAP-1 style instruction set.
//   Fetch (T1..T3) is followed by up to three exec states (E1..E3). The
//   instruction length depends on the opcode. It supports memory wait states
//   with a timeout, halt/resume and single-step pausing.
//
// Parameters
//   SKIP_EN   1: return to fetch right after the last useful exec state
//             0: pad with inactive slots up to E3 (fixed 6 T-states)
//   WAIT_MAX  consecutive wait cycles allowed in a memory state (1..255)
//   ALU_OP_W  width of alu_op
//
// Ports
//   clk           rising-edge clock
//   clr           asynchronous active-low reset
//   op_code[3:0]  IR opcode field, decoded in every exec state
//   mem_ready     memory handshake; 0 stretches the current memory state
//   run           level; leaves HALT (ignored after a wait timeout)
//   step_mode     1: pause after each instruction
//   step          rising edge releases PAUSE
//   inc, pc_out_en, acc_out_en, alu_out_en, mem_we, ld_flags   active-high
//   low_ld_mar, low_mem_out_en, low_ld_ir, low_ir_out_en,
//   low_ld_acc, low_ld_b_reg, low_halt                         active-low
//   alu_op        0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
//   t_state[5:0]  one-hot slot T1..T6; 0 in IDLE, HALT and PAUSE
//   instr_done    one-cycle pulse in an instruction's final state
//   wait_timeout  sticky timeout flag, cleared by reset only

module micro_sequencer #(
    parameter int SKIP_EN  = 1,
    parameter int WAIT_MAX = 15,
    parameter int ALU_OP_W = 3
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [3:0]          op_code,
    input  logic                mem_ready,
    input  logic                run,
    input  logic                step_mode,
    input  logic                step,
    output logic                inc,
    output logic                pc_out_en,
    output logic                acc_out_en,
    output logic                alu_out_en,
    output logic                mem_we,
    output logic                ld_flags,
    output logic                low_ld_mar,
    output logic                low_mem_out_en,
    output logic                low_ld_ir,
    output logic                low_ir_out_en,
    output logic                low_ld_acc,
    output logic                low_ld_b_reg,
    output logic                low_halt,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [5:0]          t_state,
    output logic                instr_done,
    output logic                wait_timeout
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_E1,
        S_E2,
        S_E3,
        S_HALT,
        S_PAUSE
    } state_t;

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);
    localparam logic [3:0] OP_LDA   = 4'h0;
    localparam logic [3:0] OP_STA   = 4'h1;
    localparam logic [3:0] OP_MOV   = 4'h2;
    localparam logic [3:0] OP_MVI   = 4'h3;
    localparam logic [3:0] OP_CMP   = 4'h8;
    localparam logic [3:0] OP_CPI   = 4'h9;
    localparam logic [3:0] OP_HLT   = 4'hF;

    state_t     state;
    logic       pad;        // current exec slot is NOP padding
    logic [7:0] wait_cnt;
    logic       step_q;

    logic       is_reg;
    logic       is_imm;
    logic [1:0] exec_len;
    logic       final_state;
    logic       mem_state;
    logic       alu_exec;

    // Opcode pairs (4/5, 6/7, ...) share one ALU function; CMP/CPI subtract.
    function automatic logic [2:0] alu_code(input logic [3:0] op);
        case (op[3:1])
            3'd2:    return 3'd0;
            3'd3:    return 3'd1;
            3'd4:    return 3'd1;
            3'd5:    return 3'd2;
            3'd6:    return 3'd3;
            3'd7:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Instruction classification
    always_comb begin
        is_reg = !op_code[0] && (op_code >= 4'h4);
        is_imm = op_code[0] && (op_code >= 4'h5) && (op_code != OP_HLT);

        if (is_reg) begin
            exec_len = 2'd3;
        end else if (is_imm || (op_code == OP_LDA) || (op_code == OP_STA)) begin
            exec_len = 2'd2;
        end else begin
            exec_len = 2'd1;
        end

        final_state = !pad && (((state == S_E1) && (exec_len == 2'd1)) ||
                               ((state == S_E2) && (exec_len == 2'd2)) ||
                               ((state == S_E3) && (exec_len == 2'd3)));

        mem_state = (state == S_T3) ||
                    ((state == S_E2) && !pad &&
                     ((op_code == OP_LDA) || (op_code == OP_STA) || is_reg));

        alu_exec = !pad && (((state == S_E3) && is_reg) ||
                            ((state == S_E2) && is_imm));
    end

    // State register, wait counter, timeout flag and step edge detector
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state        <= S_IDLE;
            pad          <= 1'b0;
            wait_cnt     <= '0;
            wait_timeout <= 1'b0;
            step_q       <= 1'b0;
        end else begin
            step_q <= step;
            if (mem_state && !mem_ready) begin
                // A late mem_ready on the limit cycle still avoids the
                // timeout because this branch is only taken while it is low.
                if (wait_cnt == WAIT_LIM) begin
                    wait_timeout <= 1'b1;
                    wait_cnt     <= '0;
                    pad          <= 1'b0;
                    state        <= S_HALT;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end else begin
                wait_cnt <= '0;
                pad      <= 1'b0;
                case (state)
                    S_IDLE: state <= S_T1;
                    S_T1:   state <= S_T2;
                    S_T2:   state <= S_T3;
                    S_T3:   state <= S_E1;
                    S_E1, S_E2, S_E3: begin
                        if (final_state) begin
                            if (op_code == OP_HLT) begin
                                state <= S_HALT;
                            end else if (step_mode) begin
                                state <= S_PAUSE;
                            end else if ((SKIP_EN != 0) || (state == S_E3)) begin
                                state <= S_T1;
                            end else begin
                                pad   <= 1'b1;
                                state <= (state == S_E1) ? S_E2 : S_E3;
                            end
                        end else if (state == S_E3) begin
                            state <= S_T1;
                        end else begin
                            pad   <= pad;
                            state <= (state == S_E1) ? S_E2 : S_E3;
                        end
                    end
                    S_HALT: begin
                        if (run && !wait_timeout) begin
                            state <= S_T1;
                        end
                    end
                    S_PAUSE: begin
                        if (!step_mode || (step && !step_q)) begin
                            state <= S_T1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Control decode from the state register (and the IR opcode in exec)
    always_comb begin
        inc            = 1'b0;
        pc_out_en      = 1'b0;
        acc_out_en     = 1'b0;
        alu_out_en     = 1'b0;
        mem_we         = 1'b0;
        ld_flags       = 1'b0;
        low_ld_mar     = 1'b1;
        low_mem_out_en = 1'b1;
        low_ld_ir      = 1'b1;
        low_ir_out_en  = 1'b1;
        low_ld_acc     = 1'b1;
        low_ld_b_reg   = 1'b1;
        low_halt       = 1'b1;
        alu_op         = '0;
        t_state        = '0;
        // Pulse only on the first cycle of a final state, even if it waits.
        instr_done     = final_state && (wait_cnt == '0);

        case (state)
            S_T1: begin
                t_state    = 6'h01;
                pc_out_en  = 1'b1;
                low_ld_mar = 1'b0;
            end
            S_T2: begin
                t_state = 6'h02;
                inc     = 1'b1;
            end
            S_T3: begin
                t_state        = 6'h04;
                low_mem_out_en = 1'b0;
                low_ld_ir      = 1'b0;
            end
            S_E1: begin
                t_state = 6'h08;
                if (!pad) begin
                    if ((op_code == OP_LDA) || (op_code == OP_STA) || is_reg) begin
                        low_ir_out_en = 1'b0;
                        low_ld_mar    = 1'b0;
                    end else if (op_code == OP_MOV) begin
                        acc_out_en   = 1'b1;
                        low_ld_b_reg = 1'b0;
                    end else if ((op_code == OP_MVI) || is_imm) begin
                        low_ir_out_en = 1'b0;
                        low_ld_b_reg  = 1'b0;
                    end else begin
                        low_halt = 1'b0;
                    end
                end
            end
            S_E2: begin
                t_state = 6'h10;
                if (!pad) begin
                    if (op_code == OP_LDA) begin
                        low_mem_out_en = 1'b0;
                        low_ld_acc     = 1'b0;
                    end else if (op_code == OP_STA) begin
                        acc_out_en = 1'b1;
                        mem_we     = 1'b1;
                    end else if (is_reg) begin
                        low_mem_out_en = 1'b0;
                        low_ld_b_reg   = 1'b0;
                    end
                end
            end
            S_E3: begin
                t_state = 6'h20;
            end
            S_HALT: begin
                low_halt = 1'b0;
            end
            default: ;
        endcase

        if (alu_exec) begin
            alu_out_en = 1'b1;
            ld_flags   = 1'b1;
            low_ld_acc = (op_code == OP_CMP) || (op_code == OP_CPI);
            alu_op     = ALU_OP_W'(alu_code(op_code));
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer
//   Directed bench for micro_sequencer. Three instances share the stimulus:
//   [0] SKIP_EN=1 WAIT_MAX=15, [1] SKIP_EN=0 WAIT_MAX=15,
//   [2] SKIP_EN=1 WAIT_MAX=4. Each scenario checks the instance it targets.
//   Control word packing (bit 12..0):
//   inc pc_out acc_out alu_out mem_we ld_flags | ~ld_mar ~mem_out ~ld_ir
//   ~ir_out ~ld_acc ~ld_b ~halt

module tb_micro_sequencer;

    localparam logic [12:0] INACT = 13'h007F;
    localparam logic [12:0] T1W   = 13'h083F;
    localparam logic [12:0] T2W   = 13'h107F;
    localparam logic [12:0] T3W   = 13'h004F;
    localparam logic [12:0] E1A   = 13'h0037;  // ir_out + ld_mar
    localparam logic [12:0] E1I   = 13'h0075;  // ir_out + ld_b
    localparam logic [12:0] E2R   = 13'h005D;  // mem_out + ld_b
    localparam logic [12:0] E2L   = 13'h005B;  // mem_out + ld_acc
    localparam logic [12:0] ALUA  = 13'h02FB;  // alu_out + flags + ld_acc
    localparam logic [12:0] ALUC  = 13'h02FF;  // alu_out + flags
    localparam logic [12:0] HALTW = 13'h007E;

    localparam int SKIP_T [3] = '{1, 0, 1};
    localparam int WAIT_T [3] = '{15, 15, 4};

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] op_code = 4'h0;
    logic       mem_ready = 1'b1;
    logic       run = 1'b0;
    logic       step_mode = 1'b0;
    logic       step = 1'b0;

    logic [2:0] inc_v, pc_v, acc_v, alu_v, we_v, flg_v;
    logic [2:0] mar_v, mem_v, ir_v, iro_v, lacc_v, lb_v, hlt_v;
    logic [2:0] done_v, to_v;
    logic [5:0] ts_v  [3];
    logic [2:0] aop_v [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        micro_sequencer #(
            .SKIP_EN (SKIP_T[g]),
            .WAIT_MAX(WAIT_T[g]),
            .ALU_OP_W(3)
        ) u_dut (
            .clk           (clk),
            .clr           (clr),
            .op_code       (op_code),
            .mem_ready     (mem_ready),
            .run           (run),
            .step_mode     (step_mode),
            .step          (step),
            .inc           (inc_v[g]),
            .pc_out_en     (pc_v[g]),
            .acc_out_en    (acc_v[g]),
            .alu_out_en    (alu_v[g]),
            .mem_we        (we_v[g]),
            .ld_flags      (flg_v[g]),
            .low_ld_mar    (mar_v[g]),
            .low_mem_out_en(mem_v[g]),
            .low_ld_ir     (ir_v[g]),
            .low_ir_out_en (iro_v[g]),
            .low_ld_acc    (lacc_v[g]),
            .low_ld_b_reg  (lb_v[g]),
            .low_halt      (hlt_v[g]),
            .alu_op        (aop_v[g]),
            .t_state       (ts_v[g]),
            .instr_done    (done_v[g]),
            .wait_timeout  (to_v[g])
        );
    end

    function automatic logic [12:0] cw(input int unsigned i);
        return {inc_v[i], pc_v[i], acc_v[i], alu_v[i], we_v[i], flg_v[i],
                mar_v[i], mem_v[i], ir_v[i], iro_v[i], lacc_v[i], lb_v[i],
                hlt_v[i]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_cycle(input int unsigned i, input string tag,
                                input logic [5:0] ts, input logic [12:0] w,
                                input logic done, input logic [2:0] aop);
        check({tag, "/t_state"}, 32'(ts_v[i]), 32'(ts));
        check({tag, "/ctl"}, 32'(cw(i)), 32'(w));
        check({tag, "/done"}, 32'(done_v[i]), 32'(done));
        check({tag, "/alu_op"}, 32'(aop_v[i]), 32'(aop));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves every instance in IDLE with clr released.
    task automatic reset_dut();
        clr = 1'b0;
        tick();
        tick();
        clr = 1'b1;
    endtask

    localparam logic [3:0] ALU_OPS  [3] = '{4'h8, 4'hE, 4'hA};
    localparam logic [2:0] ALU_CODE [3] = '{3'd1, 3'd4, 3'd2};
    localparam logic [12:0] ALU_CW  [3] = '{ALUC, ALUA, ALUA};

    initial begin
        // Reset state
        #1;
        for (int unsigned i = 0; i < 3; i++) begin
            expect_cycle(i, "reset", 6'h00, INACT, 1'b0, 3'd0);
            check("reset/timeout", 32'(to_v[i]), 32'd0);
        end

        // ADD, register operand, no waits
        op_code = 4'h4;
        mem_ready = 1'b1;
        reset_dut();
        expect_cycle(0, "add_idle", 6'h00, INACT, 1'b0, 3'd0);
        tick(); expect_cycle(0, "add_t1", 6'h01, T1W,  1'b0, 3'd0);
        tick(); expect_cycle(0, "add_t2", 6'h02, T2W,  1'b0, 3'd0);
        tick(); expect_cycle(0, "add_t3", 6'h04, T3W,  1'b0, 3'd0);
        tick(); expect_cycle(0, "add_e1", 6'h08, E1A,  1'b0, 3'd0);
        tick(); expect_cycle(0, "add_e2", 6'h10, E2R,  1'b0, 3'd0);
        tick(); expect_cycle(0, "add_e3", 6'h20, ALUA, 1'b1, 3'd0);
        tick(); expect_cycle(0, "add_next", 6'h01, T1W, 1'b0, 3'd0);

        // MVI with and without slot skipping
        op_code = 4'h3;
        reset_dut();
        tick();
        expect_cycle(0, "mvi_s_t1", 6'h01, T1W, 1'b0, 3'd0);
        expect_cycle(1, "mvi_p_t1", 6'h01, T1W, 1'b0, 3'd0);
        tick(); tick(); tick();
        expect_cycle(0, "mvi_s_e1", 6'h08, E1I, 1'b1, 3'd0);
        expect_cycle(1, "mvi_p_e1", 6'h08, E1I, 1'b1, 3'd0);
        tick();
        expect_cycle(0, "mvi_s_next", 6'h01, T1W, 1'b0, 3'd0);
        expect_cycle(1, "mvi_p_pad4", 6'h10, INACT, 1'b0, 3'd0);
        tick();
        expect_cycle(1, "mvi_p_pad5", 6'h20, INACT, 1'b0, 3'd0);
        tick();
        expect_cycle(1, "mvi_p_next", 6'h01, T1W, 1'b0, 3'd0);

        // LDA with three wait cycles in T3
        op_code = 4'h0;
        mem_ready = 1'b1;
        reset_dut();
        tick(); expect_cycle(0, "lda_t1", 6'h01, T1W, 1'b0, 3'd0);
        mem_ready = 1'b0;
        tick(); expect_cycle(0, "lda_t2", 6'h02, T2W, 1'b0, 3'd0);
        tick(); expect_cycle(0, "lda_t3", 6'h04, T3W, 1'b0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_cycle(0, "lda_t3_wait", 6'h04, T3W, 1'b0, 3'd0);
        end
        mem_ready = 1'b1;
        tick(); expect_cycle(0, "lda_e1", 6'h08, E1A, 1'b0, 3'd0);
        tick(); expect_cycle(0, "lda_e2", 6'h10, E2L, 1'b1, 3'd0);
        tick(); expect_cycle(0, "lda_next", 6'h01, T1W, 1'b0, 3'd0);
        check("lda_timeout", 32'(to_v[0]), 32'd0);

        // Memory stuck at LDA E2 with WAIT_MAX=4
        reset_dut();
        tick(); tick(); tick(); tick();
        expect_cycle(2, "to_e1", 6'h08, E1A, 1'b0, 3'd0);
        mem_ready = 1'b0;
        tick(); expect_cycle(2, "to_e2", 6'h10, E2L, 1'b1, 3'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_cycle(2, "to_e2_wait", 6'h10, E2L, 1'b0, 3'd0);
            check("to_flag_low", 32'(to_v[2]), 32'd0);
        end
        tick();
        expect_cycle(2, "to_halt", 6'h00, HALTW, 1'b0, 3'd0);
        check("to_flag", 32'(to_v[2]), 32'd1);
        run = 1'b1;
        tick(); tick();
        expect_cycle(2, "to_run_ignored", 6'h00, HALTW, 1'b0, 3'd0);
        check("to_flag_sticky", 32'(to_v[2]), 32'd1);
        clr = 1'b0;
        #1;
        expect_cycle(2, "to_clr", 6'h00, INACT, 1'b0, 3'd0);
        check("to_flag_clr", 32'(to_v[2]), 32'd0);
        tick();
        clr = 1'b1;
        run = 1'b0;
        mem_ready = 1'b1;

        // HLT and resume
        op_code = 4'hF;
        reset_dut();
        tick(); tick(); tick(); tick();
        expect_cycle(0, "hlt_e1", 6'h08, HALTW, 1'b1, 3'd0);
        tick();
        expect_cycle(0, "hlt_halt", 6'h00, HALTW, 1'b0, 3'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hlt_hold", 32'(cw(0)), 32'(HALTW));
        end
        run = 1'b1;
        tick(); expect_cycle(0, "hlt_resume", 6'h01, T1W, 1'b0, 3'd0);
        run = 1'b0;

        // Single step with SUI
        op_code = 4'h7;
        step_mode = 1'b1;
        step = 1'b0;
        reset_dut();
        tick(); tick(); tick(); tick();
        expect_cycle(0, "sui_e1", 6'h08, E1I, 1'b0, 3'd0);
        tick(); expect_cycle(0, "sui_e2", 6'h10, ALUA, 1'b1, 3'd1);
        tick(); expect_cycle(0, "sui_pause", 6'h00, INACT, 1'b0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("sui_pause_hold", 32'(ts_v[0]), 32'd0);
        end
        step = 1'b1;
        tick(); expect_cycle(0, "sui_step", 6'h01, T1W, 1'b0, 3'd0);
        tick(); tick(); tick(); tick();
        expect_cycle(0, "sui_e2b", 6'h10, ALUA, 1'b1, 3'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_cycle(0, "sui_step_held", 6'h00, INACT, 1'b0, 3'd0);
        end
        step_mode = 1'b0;
        tick(); expect_cycle(0, "sui_mode_off", 6'h01, T1W, 1'b0, 3'd0);
        step = 1'b0;

        // ALU code and CMP accumulator suppression in E3
        for (int unsigned j = 0; j < 3; j++) begin
            op_code = ALU_OPS[j];
            reset_dut();
            for (int k = 0; k < 6; k++) tick();
            expect_cycle(0, "alu_e3", 6'h20, ALU_CW[j], 1'b1, ALU_CODE[j]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
